// File: rtl/quad_scan_pkg.sv
// Shared types and helpers for the quadrature scan controller.
package quad_scan_pkg;

    // Scheduler states: waiting for a sample tick, or walking the channels.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Each detent of the encoder produces four edges; the reported count
    // drops these low bits of the edge total.
    localparam int EDGES_PER_CLICK_SHIFT = 2;

    // Index width able to address n items, never narrower than one bit.
    function automatic int ch_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/quad_step_decode.sv
// Combinational quadrature step decoder shared by all channels of the
// scanner. Compares the current A/B sample against the previous one.
module quad_step_decode (
    input  logic a,
    input  logic b,
    input  logic a_prev,
    input  logic b_prev,
    output logic en,
    output logic dir,
    output logic illegal
);

    // Exactly one phase moved -> a valid step; both moved -> lost edge.
    always_comb begin
        en      = a ^ a_prev ^ b ^ b_prev;
        dir     = a ^ b_prev;
        illegal = (a ^ a_prev) & (b ^ b_prev);
    end

endmodule

// File: rtl/quad_scan_ctrl.sv
// Round-robin quadrature scanner: one step decoder is time-shared across
// NUM_CH encoders on a prescaled sample tick. Per-channel edge totals,
// previous phase state and status flags live in a small register file that
// the host reads through a request/acknowledge port and zeroes through a
// per-channel clear port.
module quad_scan_ctrl
    import quad_scan_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 50,
    parameter int CH_W     = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] quadA,
    input  logic [NUM_CH-1:0] quadB,
    input  logic              rd_req,
    input  logic [CH_W-1:0]   rd_ch,
    output logic              rd_ack,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_err,
    input  logic              clr_req,
    input  logic [CH_W-1:0]   clr_ch,
    output logic [NUM_CH-1:0] changed,
    output logic              busy,
    output logic              overrun
);

    localparam int SHIFT = EDGES_PER_CLICK_SHIFT;
    localparam int TOT_W = CNT_W + SHIFT;
    localparam int PS_W  = ch_width(PRESCALE);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    // Input synchronizers
    logic [NUM_CH-1:0] qa_meta_r, qa_sync_r;
    logic [NUM_CH-1:0] qb_meta_r, qb_sync_r;

    // Prescaler
    logic [PS_W-1:0] presc_r;
    logic            tick_s;

    // Scheduler
    scan_state_t       state_r;
    logic [CH_W-1:0]   ch_idx_r;
    logic              primed_r;
    logic              busy_r;
    logic              overrun_r;
    logic [NUM_CH-1:0] snap_a_r, snap_b_r;

    // Register file
    logic [TOT_W-1:0]  total_r     [NUM_CH];
    logic [TOT_W-1:0]  total_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] prev_a_r, prev_b_r, err_r, changed_r;
    logic [NUM_CH-1:0] prev_a_nxt_s, prev_b_nxt_s, err_nxt_s, changed_nxt_s;
    logic [NUM_CH-1:0] scan_slot_s, clr_hit_s, rd_hit_s, chg_set_s;

    // Shared decoder datapath
    logic             cur_a_s, cur_b_s, cur_pa_s, cur_pb_s;
    logic             dec_en_s, dec_dir_s, dec_illegal_s;
    logic             count_step_s, err_step_s;
    logic [TOT_W-1:0] step_delta_s;

    // Read port
    logic             rd_ack_r, rd_err_r;
    logic [CNT_W-1:0] rd_data_r;
    logic [CNT_W-1:0] rd_count_s;
    logic             rd_err_s;

    // Two-flop synchronizer for the asynchronous encoder phases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qa_meta_r <= '0;
            qa_sync_r <= '0;
            qb_meta_r <= '0;
            qb_sync_r <= '0;
        end else begin
            qa_meta_r <= quadA;
            qa_sync_r <= qa_meta_r;
            qb_meta_r <= quadB;
            qb_sync_r <= qb_meta_r;
        end
    end

    // Free-running sample prescaler, wrapping at PRESCALE-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r <= '0;
        end else if (presc_r == PS_LAST) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PS_W'(1);
        end
    end

    assign tick_s = (presc_r == PS_LAST);

    // Scan scheduler: snapshot on a tick, then one channel per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            ch_idx_r  <= '0;
            primed_r  <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
            snap_a_r  <= '0;
            snap_b_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        snap_a_r <= qa_sync_r;
                        snap_b_r <= qb_sync_r;
                        ch_idx_r <= '0;
                        state_r  <= ST_SCAN;
                        busy_r   <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // A tick cannot be serviced mid-scan; it is dropped.
                    if (tick_s) begin
                        overrun_r <= 1'b1;
                    end
                    if (ch_idx_r == LAST_CH) begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        primed_r <= 1'b1;
                        ch_idx_r <= '0;
                    end else begin
                        ch_idx_r <= ch_idx_r + CH_W'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    ch_idx_r <= '0;
                end
            endcase
        end
    end

    // Route the channel under scan into the shared decoder.
    always_comb begin
        cur_a_s  = 1'b0;
        cur_b_s  = 1'b0;
        cur_pa_s = 1'b0;
        cur_pb_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_a_s  = (ch_idx_r == CH_W'(i)) ? snap_a_r[i] : cur_a_s;
            cur_b_s  = (ch_idx_r == CH_W'(i)) ? snap_b_r[i] : cur_b_s;
            cur_pa_s = (ch_idx_r == CH_W'(i)) ? prev_a_r[i] : cur_pa_s;
            cur_pb_s = (ch_idx_r == CH_W'(i)) ? prev_b_r[i] : cur_pb_s;
        end
    end

    quad_step_decode u_decode (
        .a       (cur_a_s),
        .b       (cur_b_s),
        .a_prev  (cur_pa_s),
        .b_prev  (cur_pb_s),
        .en      (dec_en_s),
        .dir     (dec_dir_s),
        .illegal (dec_illegal_s)
    );

    // Until one full scan has loaded prev, the decoder output is meaningless.
    always_comb begin
        count_step_s = primed_r & dec_en_s;
        err_step_s   = primed_r & dec_illegal_s;
        step_delta_s = dec_dir_s ? TOT_W'(1) : {TOT_W{1'b1}};
    end

    // Per-channel hit decode for scan slot, clear and read.
    always_comb begin
        scan_slot_s = '0;
        clr_hit_s   = '0;
        rd_hit_s    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_slot_s[i] = (state_r == ST_SCAN) && (ch_idx_r == CH_W'(i));
            clr_hit_s[i]   = clr_req && (clr_ch == CH_W'(i));
            rd_hit_s[i]    = rd_req && (rd_ch == CH_W'(i));
        end
    end

    // Register-file next state: clear beats scan update, set beats read-clear.
    always_comb begin
        chg_set_s     = '0;
        prev_a_nxt_s  = prev_a_r;
        prev_b_nxt_s  = prev_b_r;
        err_nxt_s     = err_r;
        changed_nxt_s = changed_r;
        for (int i = 0; i < NUM_CH; i++) begin
            total_nxt_s[i] = total_r[i];
            if (clr_hit_s[i]) begin
                total_nxt_s[i] = '0;
                chg_set_s[i]   = |total_r[i][TOT_W-1:SHIFT];
            end else if (scan_slot_s[i] && count_step_s) begin
                total_nxt_s[i] = total_r[i] + step_delta_s;
                chg_set_s[i]   = ((total_r[i] + step_delta_s) >> SHIFT)
                                 != (total_r[i] >> SHIFT);
            end else begin
                total_nxt_s[i] = total_r[i];
                chg_set_s[i]   = 1'b0;
            end
            // prev tracks the snapshot even when the count update is discarded.
            prev_a_nxt_s[i]  = scan_slot_s[i] ? snap_a_r[i] : prev_a_r[i];
            prev_b_nxt_s[i]  = scan_slot_s[i] ? snap_b_r[i] : prev_b_r[i];
            err_nxt_s[i]     = (scan_slot_s[i] & err_step_s) | (err_r[i] & ~rd_hit_s[i]);
            changed_nxt_s[i] = chg_set_s[i] | (changed_r[i] & ~rd_hit_s[i]);
        end
    end

    // Register-file state update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                total_r[i] <= '0;
            end
            prev_a_r  <= '0;
            prev_b_r  <= '0;
            err_r     <= '0;
            changed_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                total_r[i] <= total_nxt_s[i];
            end
            prev_a_r  <= prev_a_nxt_s;
            prev_b_r  <= prev_b_nxt_s;
            err_r     <= err_nxt_s;
            changed_r <= changed_nxt_s;
        end
    end

    // Read mux over pre-update state; out-of-range channels read as zero.
    always_comb begin
        rd_count_s = '0;
        rd_err_s   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_count_s = (rd_ch == CH_W'(i)) ? total_r[i][TOT_W-1:SHIFT] : rd_count_s;
            rd_err_s   = (rd_ch == CH_W'(i)) ? err_r[i] : rd_err_s;
        end
    end

    // Read response register: one acknowledge per request, next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ack_r  <= 1'b0;
            rd_data_r <= '0;
            rd_err_r  <= 1'b0;
        end else begin
            rd_ack_r <= rd_req;
            if (rd_req) begin
                rd_data_r <= rd_count_s;
                rd_err_r  <= rd_err_s;
            end else begin
                rd_data_r <= '0;
                rd_err_r  <= 1'b0;
            end
        end
    end

    assign rd_ack  = rd_ack_r;
    assign rd_data = rd_data_r;
    assign rd_err  = rd_err_r;
    assign changed = changed_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_quad_scan_ctrl.sv
// Self-checking bench for quad_scan_ctrl. A main instance runs a legal
// prescale; a second, fast-ticking instance exercises overrun and
// out-of-range channel handling. Expected values come from a Gray-position
// edge model of each encoder.
module tb_quad_scan_ctrl;

    localparam int NCH    = 4;
    localparam int PRE    = 8;
    localparam int HOLD   = 2 * PRE + 4;
    localparam int F_HOLD = 10;

    logic       clk = 1'b0;
    logic       reset;

    logic [3:0] quadA, quadB;
    logic       rd_req, rd_ack, rd_err, clr_req, busy, overrun;
    logic [1:0] rd_ch, clr_ch;
    logic [7:0] rd_data;
    logic [3:0] changed;

    logic [2:0] f_qa, f_qb, f_changed;
    logic       f_rd_req, f_rd_ack, f_rd_err, f_clr_req, f_busy, f_overrun;
    logic [1:0] f_rd_ch, f_clr_ch;
    logic [7:0] f_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the main instance
    int         m_total [NCH];
    bit         m_err   [NCH];
    bit         m_chg   [NCH];
    logic [1:0] m_ab    [NCH];

    always #5 clk = ~clk;

    quad_scan_ctrl #(.NUM_CH(4), .CNT_W(8), .PRESCALE(PRE)) u_dut (
        .clk(clk), .reset(reset), .quadA(quadA), .quadB(quadB),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_ack(rd_ack), .rd_data(rd_data),
        .rd_err(rd_err), .clr_req(clr_req), .clr_ch(clr_ch),
        .changed(changed), .busy(busy), .overrun(overrun)
    );

    quad_scan_ctrl #(.NUM_CH(3), .CNT_W(8), .PRESCALE(2)) u_fast (
        .clk(clk), .reset(reset), .quadA(f_qa), .quadB(f_qb),
        .rd_req(f_rd_req), .rd_ch(f_rd_ch), .rd_ack(f_rd_ack), .rd_data(f_rd_data),
        .rd_err(f_rd_err), .clr_req(f_clr_req), .clr_ch(f_clr_ch),
        .changed(f_changed), .busy(f_busy), .overrun(f_overrun)
    );

    // Position of an AB state along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic int gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [NCH-1:0] model_changed();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_chg[i];
        return v;
    endfunction

    // Move one main channel to a new AB state, hold, then update the model.
    task automatic step_ch(input int ch, input logic [1:0] ab);
        int d;
        int old_cnt;
        @(negedge clk);
        quadA[ch] = ab[1];
        quadB[ch] = ab[0];
        repeat (HOLD) @(negedge clk);
        d = (gray_pos(ab) - gray_pos(m_ab[ch])) & 3;
        old_cnt = m_total[ch] / 4;
        if (d == 1) m_total[ch] = (m_total[ch] + 1) % 1024;
        else if (d == 3) m_total[ch] = (m_total[ch] + 1023) % 1024;
        else if (d == 2) m_err[ch] = 1'b1;
        if (m_total[ch] / 4 != old_cnt) m_chg[ch] = 1'b1;
        m_ab[ch] = ab;
    endtask

    // Move a fast-instance channel to a new AB state and hold.
    task automatic f_step(input int ch, input logic [1:0] ab);
        @(negedge clk);
        f_qa[ch] = ab[1];
        f_qb[ch] = ab[0];
        repeat (F_HOLD) @(negedge clk);
    endtask

    // One read transaction; returns the ack cycle values and the next ack.
    task automatic rd_txn(input bit fast, input int ch, output logic ack1,
                          output logic [7:0] data, output logic err, output logic ack2);
        @(negedge clk);
        if (fast) begin
            f_rd_req = 1'b1; f_rd_ch = 2'(ch);
        end else begin
            rd_req = 1'b1; rd_ch = 2'(ch);
        end
        @(negedge clk);
        rd_req = 1'b0; f_rd_req = 1'b0;
        ack1 = fast ? f_rd_ack : rd_ack;
        data = fast ? f_rd_data : rd_data;
        err  = fast ? f_rd_err : rd_err;
        @(negedge clk);
        ack2 = fast ? f_rd_ack : rd_ack;
    endtask

    task automatic wait_busy(input logic lvl, output bit ok);
        int cnt = 0;
        while (busy !== lvl && cnt < 4 * PRE) begin
            @(negedge clk);
            cnt++;
        end
        ok = (busy === lvl);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        quadA = 4'b0001; quadB = 4'b0001;   // ch0 held at A=1,B=1
        f_qa = 3'b000; f_qb = 3'b000;
        rd_req = 1'b0; rd_ch = 2'd0; clr_req = 1'b0; clr_ch = 2'd0;
        f_rd_req = 1'b0; f_rd_ch = 2'd0; f_clr_req = 1'b0; f_clr_ch = 2'd0;
        for (int i = 0; i < NCH; i++) begin
            m_total[i] = 0; m_err[i] = 1'b0; m_chg[i] = 1'b0;
            m_ab[i] = (i == 0) ? 2'b11 : 2'b00;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if ({rd_ack, rd_data, rd_err, changed, busy, overrun} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0000",
                     {rd_ack, rd_data, rd_err, changed, busy, overrun});
        end
        reset = 1'b1;
        repeat (HOLD) @(negedge clk);
        n_checks++;
        if (changed !== 4'b0000) begin
            n_fail++;
            $display("FAIL prime_changed: got %b, required 0000", changed);
        end
    endtask

    task automatic test_prime_read();
        logic a1, a2, e;
        logic [7:0] d;
        rd_txn(1'b0, 0, a1, d, e, a2);
        n_checks++;
        if (a1 !== 1'b1 || d !== 8'h00 || e !== 1'b0 || a2 !== 1'b0) begin
            n_fail++;
            $display("FAIL prime_read: ack=%b data=%h err=%b next_ack=%b, required 1 00 0 0",
                     a1, d, e, a2);
        end
    endtask

    task automatic test_busy();
        bit ok;
        int cyc = 0;
        wait_busy(1'b1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL busy_timeout: busy=%b, required 1 within %0d cycles", busy, 4 * PRE);
        end
        while (busy === 1'b1 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (cyc != NCH) begin
            n_fail++;
            $display("FAIL busy_width: got %0d cycles, required %0d", cyc, NCH);
        end
    endtask

    task automatic test_forward();
        logic a1, a2, e;
        logic [7:0] d;
        step_ch(1, 2'b10); step_ch(1, 2'b11); step_ch(1, 2'b01); step_ch(1, 2'b00);
        n_checks++;
        if (changed !== model_changed() || changed[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_changed: got %b, required %b", changed, model_changed());
        end
        rd_txn(1'b0, 1, a1, d, e, a2);
        n_checks++;
        if (a1 !== 1'b1 || d !== 8'h01 || e !== 1'b0 || a2 !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_read: ack=%b data=%h err=%b next_ack=%b, required 1 01 0 0",
                     a1, d, e, a2);
        end
        m_chg[1] = 1'b0; m_err[1] = 1'b0;
        n_checks++;
        if (changed[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_changed_clr: got %b, required 0", changed[1]);
        end
    endtask

    task automatic test_reverse();
        logic a1, a2, e;
        logic [7:0] d;
        for (int k = 0; k < 3; k++) begin
            step_ch(2, 2'b01); step_ch(2, 2'b11); step_ch(2, 2'b10); step_ch(2, 2'b00);
        end
        rd_txn(1'b0, 2, a1, d, e, a2);
        n_checks++;
        if (a1 !== 1'b1 || d !== 8'hFD || d !== 8'(m_total[2] / 4) || e !== 1'b0) begin
            n_fail++;
            $display("FAIL rev_read: ack=%b data=%h err=%b, required 1 fd 0", a1, d, e);
        end
        m_chg[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step_ch(2, 2'b10); step_ch(2, 2'b11); step_ch(2, 2'b01); step_ch(2, 2'b00);
        end
        rd_txn(1'b0, 2, a1, d, e, a2);
        n_checks++;
        if (a1 !== 1'b1 || d !== 8'h00 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL rev_back_read: ack=%b data=%h err=%b, required 1 00 0", a1, d, e);
        end
        m_chg[2] = 1'b0;
    endtask

    task automatic test_illegal();
        logic a1, a2, e;
        logic [7:0] d;
        step_ch(3, 2'b11);
        n_checks++;
        if (changed !== model_changed()) begin
            n_fail++;
            $display("FAIL illegal_changed: got %b, required %b", changed, model_changed());
        end
        rd_txn(1'b0, 3, a1, d, e, a2);
        n_checks++;
        if (a1 !== 1'b1 || d !== 8'h00 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_read1: ack=%b data=%h err=%b, required 1 00 1", a1, d, e);
        end
        m_err[3] = 1'b0; m_chg[3] = 1'b0;
        rd_txn(1'b0, 3, a1, d, e, a2);
        n_checks++;
        if (a1 !== 1'b1 || d !== 8'h00 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_read2: ack=%b data=%h err=%b, required 1 00 0", a1, d, e);
        end
    endtask

    task automatic test_clear_race();
        bit ok1, ok2, ok3;
        logic a1, a2, e;
        logic [7:0] d;
        wait_busy(1'b1, ok1);
        wait_busy(1'b0, ok2);
        quadA[1] = 1'b1; quadB[1] = 1'b0;      // 00 -> 10, forward edge
        wait_busy(1'b1, ok3);                  // this cycle scans ch0
        n_checks++;
        if (!(ok1 && ok2 && ok3)) begin
            n_fail++;
            $display("FAIL race_sync: busy handshakes %b%b%b, required 111", ok1, ok2, ok3);
        end
        @(negedge clk);                        // ch1 slot
        clr_req = 1'b1; clr_ch = 2'd1;
        @(negedge clk);
        clr_req = 1'b0;
        m_chg[1] = (m_total[1] / 4 != 0) ? 1'b1 : m_chg[1];
        m_total[1] = 0;
        m_ab[1] = 2'b10;
        repeat (HOLD) @(negedge clk);
        n_checks++;
        if (changed !== model_changed()) begin
            n_fail++;
            $display("FAIL race_changed: got %b, required %b", changed, model_changed());
        end
        rd_txn(1'b0, 1, a1, d, e, a2);
        n_checks++;
        if (a1 !== 1'b1 || d !== 8'h00) begin
            n_fail++;
            $display("FAIL race_read: ack=%b data=%h, required 1 00", a1, d);
        end
        m_chg[1] = 1'b0;
        step_ch(1, 2'b11);                     // total 1, count still 0
        rd_txn(1'b0, 1, a1, d, e, a2);
        n_checks++;
        if (d !== 8'h00 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL race_next_edge: data=%h err=%b, required 00 0", d, e);
        end
        step_ch(1, 2'b01); step_ch(1, 2'b00); step_ch(1, 2'b10);
        rd_txn(1'b0, 1, a1, d, e, a2);
        n_checks++;
        if (d !== 8'h01 || d !== 8'(m_total[1] / 4) || e !== 1'b0) begin
            n_fail++;
            $display("FAIL race_total_one: data=%h err=%b, required 01 0", d, e);
        end
        m_chg[1] = 1'b0;
    endtask

    task automatic test_random();
        logic a1, a2, e;
        logic [7:0] d;
        int ch;
        for (int it = 0; it < 24; it++) begin
            ch = $urandom_range(0, NCH - 1);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                clr_req = 1'b1; clr_ch = 2'(ch);
                @(negedge clk);
                clr_req = 1'b0;
                if (m_total[ch] / 4 != 0) m_chg[ch] = 1'b1;
                m_total[ch] = 0;
                @(negedge clk);
            end else begin
                step_ch(ch, 2'($urandom_range(0, 3)));
            end
            n_checks++;
            if (changed !== model_changed()) begin
                n_fail++;
                $display("FAIL rand_changed it=%0d: got %b, required %b",
                         it, changed, model_changed());
            end
            if (it % 4 == 3) begin
                ch = $urandom_range(0, NCH - 1);
                rd_txn(1'b0, ch, a1, d, e, a2);
                n_checks++;
                if (a1 !== 1'b1 || d !== 8'(m_total[ch] / 4) || e !== m_err[ch] || a2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_read ch%0d: ack=%b data=%h err=%b, required 1 %h %b",
                             ch, a1, d, e, 8'(m_total[ch] / 4), m_err[ch]);
                end
                m_chg[ch] = 1'b0; m_err[ch] = 1'b0;
            end
        end
    endtask

    task automatic test_fast();
        logic a1, a2, e;
        logic [7:0] d;
        logic [2:0] chg_before;
        n_checks++;
        if (f_overrun !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_flag: fast=%b main=%b, required 1 0", f_overrun, overrun);
        end
        for (int k = 0; k < 2; k++) begin
            f_step(0, 2'b10); f_step(0, 2'b11); f_step(0, 2'b01); f_step(0, 2'b00);
        end
        f_step(1, 2'b01); f_step(1, 2'b11); f_step(1, 2'b10); f_step(1, 2'b00);
        rd_txn(1'b1, 0, a1, d, e, a2);
        n_checks++;
        if (a1 !== 1'b1 || d !== 8'h02 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_total0: ack=%b data=%h err=%b, required 1 02 0", a1, d, e);
        end
        rd_txn(1'b1, 1, a1, d, e, a2);
        n_checks++;
        if (a1 !== 1'b1 || d !== 8'hFF || e !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_total1: ack=%b data=%h err=%b, required 1 ff 0", a1, d, e);
        end
        rd_txn(1'b1, 3, a1, d, e, a2);
        n_checks++;
        if (a1 !== 1'b1 || d !== 8'h00 || e !== 1'b0 || a2 !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_read: ack=%b data=%h err=%b next_ack=%b, required 1 00 0 0",
                     a1, d, e, a2);
        end
        chg_before = f_changed;
        @(negedge clk);
        f_clr_req = 1'b1; f_clr_ch = 2'd3;
        @(negedge clk);
        f_clr_req = 1'b0;
        repeat (3) @(negedge clk);
        rd_txn(1'b1, 0, a1, d, e, a2);
        n_checks++;
        if (f_changed !== chg_before || d !== 8'h02 || f_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_clear: changed=%b data=%h overrun=%b, required %b 02 1",
                     f_changed, d, f_overrun, chg_before);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        logic a1, a2, e;
        logic [7:0] d;
        wait_busy(1'b1, ok);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (!ok || {rd_ack, rd_data, rd_err, changed, busy, overrun, f_overrun, f_busy, f_changed} !== 21'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy_seen=%b got %h, required 0",
                     ok, {rd_ack, rd_data, rd_err, changed, busy, overrun, f_overrun, f_busy, f_changed});
        end
        quadA[2] = 1'b1; quadB[2] = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            m_total[i] = 0; m_err[i] = 1'b0; m_chg[i] = 1'b0;
        end
        m_ab[2] = 2'b11;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2 * HOLD) @(negedge clk);
        rd_txn(1'b0, 2, a1, d, e, a2);
        n_checks++;
        if (changed !== 4'b0000 || a1 !== 1'b1 || d !== 8'h00 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reprime: changed=%b ack=%b data=%h err=%b, required 0000 1 00 0",
                     changed, a1, d, e);
        end
    endtask

    initial begin
        test_reset();
        test_prime_read();
        test_busy();
        test_forward();
        test_reverse();
        test_illegal();
        test_clear_race();
        test_random();
        test_fast();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
